// File: rtl/victim_buffer_if.sv
// victim_buffer_if
//   Bundles the insert, lookup/result and writeback channels of the victim buffer.
//   slave  : the victim buffer itself
//   master : the L1 / memory-controller side (or a testbench driving it)
//   Insert    : ins_valid/ins_ready, line fields ins_set/ins_tag/ins_data/ins_dirty
//   Lookup    : lk_valid with key lk_set/lk_tag; results hit_valid/hit_data/hit_dirty
//               and miss_valid one cycle later
//   Writeback : wb_valid/wb_ready with line fields wb_set/wb_tag/wb_data
// Handshake rule for both ready/valid channels: a transfer happens on a rising
// clock edge where valid and ready are both 1. ins_ready may depend
// combinationally on the current lookup and on wb_ready.
interface victim_buffer_if #(
   parameter int SET_BITS  = 4,
   parameter int TAG_BITS  = 8,
   parameter int DATA_BITS = 64
);
   logic                 ins_valid;
   logic                 ins_ready;
   logic [SET_BITS-1:0]  ins_set;
   logic [TAG_BITS-1:0]  ins_tag;
   logic [DATA_BITS-1:0] ins_data;
   logic                 ins_dirty;

   logic                 lk_valid;
   logic [SET_BITS-1:0]  lk_set;
   logic [TAG_BITS-1:0]  lk_tag;
   logic                 hit_valid;
   logic [DATA_BITS-1:0] hit_data;
   logic                 hit_dirty;
   logic                 miss_valid;

   logic                 wb_valid;
   logic                 wb_ready;
   logic [SET_BITS-1:0]  wb_set;
   logic [TAG_BITS-1:0]  wb_tag;
   logic [DATA_BITS-1:0] wb_data;

   modport slave (
      input  ins_valid, ins_set, ins_tag, ins_data, ins_dirty,
      output ins_ready,
      input  lk_valid, lk_set, lk_tag,
      output hit_valid, hit_data, hit_dirty, miss_valid,
      output wb_valid, wb_set, wb_tag, wb_data,
      input  wb_ready
   );

   modport master (
      output ins_valid, ins_set, ins_tag, ins_data, ins_dirty,
      input  ins_ready,
      output lk_valid, lk_set, lk_tag,
      input  hit_valid, hit_data, hit_dirty, miss_valid,
      input  wb_valid, wb_set, wb_tag, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/victim_buffer.sv
// victim_buffer
//   Fully associative buffer of the last DEPTH lines evicted from L1. Entries are
//   kept compacted with the newest line at index 0. A lookup hit returns the line
//   and removes it; overflowing evicts the oldest line, dirty ones leave through a
//   single-entry writeback register. A flush drains the buffer oldest-first.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : insert / lookup / writeback channels (victim_buffer_if.slave)
//   flush        : start a flush, sampled while idle
//   flush_done   : one-cycle pulse after the flush has fully drained
//   ent_valid    : per-entry valid bits, bit 0 = newest
//   count        : number of valid entries
//   state_dbg    : current FSM state (0 = IDLE, 1 = FLUSH)
module victim_buffer #(
   parameter int DEPTH     = 4,
   parameter int SET_BITS  = 4,
   parameter int TAG_BITS  = 8,
   parameter int DATA_BITS = 64,
   localparam int CW       = $clog2(DEPTH + 1),
   localparam int IW       = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   victim_buffer_if.slave   bus,
   input  logic             flush,
   output logic             flush_done,
   output logic [DEPTH-1:0] ent_valid,
   output logic [CW-1:0]    count,
   output logic             state_dbg
);
   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [SET_BITS-1:0]  set;
      logic [TAG_BITS-1:0]  tag;
      logic [DATA_BITS-1:0] data;
   } ent_t;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   ent_t                 ent_q [DEPTH];
   ent_t                 ent_d [DEPTH];
   ent_t                 new_ent;
   logic [CW-1:0]        count_q, count_d;
   state_t               state_q, state_d;
   logic                 flush_done_q, flush_done_d;

   logic                 wb_valid_q, wb_valid_d;
   logic [SET_BITS-1:0]  wb_set_q, wb_set_d;
   logic [TAG_BITS-1:0]  wb_tag_q, wb_tag_d;
   logic [DATA_BITS-1:0] wb_data_q, wb_data_d;

   logic                 hit_valid_q, miss_valid_q, hit_dirty_q;
   logic [DATA_BITS-1:0] hit_data_q;

   logic                 lk_hit;
   logic [IW-1:0]        hit_idx;
   logic                 wb_free;
   logic                 oldest_blocks;
   logic                 ins_fire;

   assign new_ent = {1'b1, bus.ins_dirty, bus.ins_set, bus.ins_tag, bus.ins_data};

   // CAM search; scanning downward leaves the lowest matching index in hit_idx.
   always_comb begin
      lk_hit  = 1'b0;
      hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (bus.lk_valid && ent_q[i].valid &&
             ent_q[i].set == bus.lk_set && ent_q[i].tag == bus.lk_tag) begin
            lk_hit  = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   // The writeback register can take a new line if it is empty or draining now.
   assign wb_free       = !wb_valid_q || bus.wb_ready;
   // An insert into a full buffer would push out a dirty line with nowhere to go.
   assign oldest_blocks = (count_q == FULL) && ent_q[DEPTH-1].dirty && !lk_hit &&
                          wb_valid_q && !bus.wb_ready;
   assign bus.ins_ready = (state_q == IDLE) && !oldest_blocks;
   assign ins_fire      = bus.ins_valid && bus.ins_ready;

   // Entry array, count and writeback register next-state.
   always_comb begin
      ent_d      = ent_q;
      count_d    = count_q;
      wb_valid_d = wb_valid_q;
      wb_set_d   = wb_set_q;
      wb_tag_d   = wb_tag_q;
      wb_data_d  = wb_data_q;
      if (wb_valid_q && bus.wb_ready)
         wb_valid_d = 1'b0;

      if (ins_fire) begin
         // With a hit at k only 0..k-1 shift up, overwriting (removing) entry k.
         for (int i = 1; i < DEPTH; i++) begin
            if (!lk_hit || i <= int'(hit_idx))
               ent_d[i] = ent_q[i-1];
         end
         ent_d[0] = new_ent;
         if (!lk_hit) begin
            if (count_q == FULL) begin
               if (ent_q[DEPTH-1].dirty) begin
                  wb_valid_d = 1'b1;
                  wb_set_d   = ent_q[DEPTH-1].set;
                  wb_tag_d   = ent_q[DEPTH-1].tag;
                  wb_data_d  = ent_q[DEPTH-1].data;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
      end else if (lk_hit) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(hit_idx))
               ent_d[i] = ent_q[i+1];
         end
         ent_d[DEPTH-1] = '0;
         count_d        = count_q - 1'b1;
      end else if (state_q == FLUSH && wb_free && count_q != '0) begin
         // Drain the oldest entry; a hit above has priority over draining.
         for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(count_q) - 1) begin
               ent_d[i] = '0;
               if (ent_q[i].dirty) begin
                  wb_valid_d = 1'b1;
                  wb_set_d   = ent_q[i].set;
                  wb_tag_d   = ent_q[i].tag;
                  wb_data_d  = ent_q[i].data;
               end
            end
         end
         count_d = count_q - 1'b1;
      end
   end

   // FSM next-state.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      case (state_q)
         IDLE: if (flush) state_d = FLUSH;
         FLUSH: begin
            if (count_q == '0 && wb_free) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         count_q      <= '0;
         state_q      <= IDLE;
         flush_done_q <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_set_q     <= '0;
         wb_tag_q     <= '0;
         wb_data_q    <= '0;
         hit_valid_q  <= 1'b0;
         miss_valid_q <= 1'b0;
         hit_dirty_q  <= 1'b0;
         hit_data_q   <= '0;
      end else begin
         ent_q        <= ent_d;
         count_q      <= count_d;
         state_q      <= state_d;
         flush_done_q <= flush_done_d;
         wb_valid_q   <= wb_valid_d;
         wb_set_q     <= wb_set_d;
         wb_tag_q     <= wb_tag_d;
         wb_data_q    <= wb_data_d;
         hit_valid_q  <= lk_hit;
         miss_valid_q <= bus.lk_valid && !lk_hit;
         if (lk_hit) begin
            hit_data_q  <= ent_q[hit_idx].data;
            hit_dirty_q <= ent_q[hit_idx].dirty;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_valid[i] = ent_q[i].valid;
   end

   assign count          = count_q;
   assign flush_done     = flush_done_q;
   assign state_dbg      = state_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_set     = wb_set_q;
   assign bus.wb_tag     = wb_tag_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.hit_valid  = hit_valid_q;
   assign bus.miss_valid = miss_valid_q;
   assign bus.hit_data   = hit_data_q;
   assign bus.hit_dirty  = hit_dirty_q;
endmodule

// File: tb/tb_victim_buffer.sv
// tb_victim_buffer
//   Directed scenarios followed by random traffic for victim_buffer. The
//   reference model is a queue of lines (front = newest) updated with the
//   buffer's rules once per clock; every cycle the DUT outputs are compared
//   against it.
module tb_victim_buffer;
   localparam int DEPTH = 4;
   localparam int SB    = 4;
   localparam int TB    = 8;
   localparam int DB    = 64;

   typedef struct {
      logic [SB-1:0] s;
      logic [TB-1:0] t;
      logic [DB-1:0] d;
      logic          dirty;
   } line_t;

   // ---------------- clock / reset ----------------
   logic             clock = 1'b0;
   logic             reset;
   logic             flush;
   logic             flush_done;
   logic [DEPTH-1:0] ent_valid;
   logic [2:0]       count;
   logic             state_dbg;

   always #5 clock = ~clock;

   victim_buffer_if #(.SET_BITS(SB), .TAG_BITS(TB), .DATA_BITS(DB)) bus ();

   victim_buffer #(.DEPTH(DEPTH), .SET_BITS(SB), .TAG_BITS(TB), .DATA_BITS(DB)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .flush      (flush),
      .flush_done (flush_done),
      .ent_valid  (ent_valid),
      .count      (count),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard / model state ----------------
   int              n_checks = 0;
   int              n_errors = 0;
   line_t           mq[$];
   logic            m_wb_v;
   line_t           m_wb;
   logic            m_flushing;
   logic [TB-1:0]   hs_tags[$];
   int              dut_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_wb_v     = 1'b0;
      m_flushing = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_ins(input bit v, input int s, input int t, input logic [DB-1:0] d, input bit dirty);
      bus.ins_valid = v;
      bus.ins_set   = SB'(s);
      bus.ins_tag   = TB'(t);
      bus.ins_data  = d;
      bus.ins_dirty = dirty;
   endtask

   task automatic set_lk(input bit v, input int s, input int t);
      bus.lk_valid = v;
      bus.lk_set   = SB'(s);
      bus.lk_tag   = TB'(t);
   endtask

   // One clock: check ins_ready, advance the model, then check registered outputs.
   task automatic cycle();
      int    k;
      int    sz;
      bit    hit, lkv, fire, wb_free, load, exp_ready, done;
      line_t nl, ev, hl;
      #1;
      nl  = '{s: bus.ins_set, t: bus.ins_tag, d: bus.ins_data, dirty: bus.ins_dirty};
      sz  = mq.size();
      lkv = bus.lk_valid;
      k   = -1;
      if (lkv) begin
         foreach (mq[i]) if (k < 0 && mq[i].s == bus.lk_set && mq[i].t == bus.lk_tag) k = i;
      end
      hit = (k >= 0);
      if (hit) hl = mq[k];
      exp_ready = !m_flushing;
      if (sz == DEPTH) begin
         if (mq[DEPTH-1].dirty && !hit && m_wb_v && !bus.wb_ready) exp_ready = 1'b0;
      end
      chk("ins_ready", bus.ins_ready, exp_ready);
      fire    = bus.ins_valid && exp_ready;
      wb_free = !m_wb_v || bus.wb_ready;
      if (bus.wb_valid && bus.wb_ready) hs_tags.push_back(bus.wb_tag);

      load = 1'b0;
      if (fire) begin
         if (hit) mq.delete(k);
         mq.push_front(nl);
         if (mq.size() > DEPTH) begin
            ev   = mq.pop_back();
            load = ev.dirty;
         end
      end else if (hit) begin
         mq.delete(k);
      end else if (m_flushing && wb_free && sz > 0) begin
         ev   = mq.pop_back();
         load = ev.dirty;
      end

      done = 1'b0;
      if (!m_flushing) begin
         if (flush) m_flushing = 1'b1;
      end else if (sz == 0 && wb_free) begin
         m_flushing = 1'b0;
         done       = 1'b1;
      end

      if (load) begin
         m_wb   = ev;
         m_wb_v = 1'b1;
      end else if (m_wb_v && bus.wb_ready) begin
         m_wb_v = 1'b0;
      end

      @(posedge clock);
      #1;
      chk("count", count, mq.size());
      chk("ent_valid", ent_valid, (64'd1 << mq.size()) - 64'd1);
      chk("hit_valid", bus.hit_valid, hit);
      chk("miss_valid", bus.miss_valid, lkv && !hit);
      if (hit) begin
         chk("hit_data", bus.hit_data, hl.d);
         chk("hit_dirty", bus.hit_dirty, hl.dirty);
      end
      chk("wb_valid", bus.wb_valid, m_wb_v);
      if (m_wb_v) begin
         chk("wb_set", bus.wb_set, m_wb.s);
         chk("wb_tag", bus.wb_tag, m_wb.t);
         chk("wb_data", bus.wb_data, m_wb.d);
      end
      chk("flush_done", flush_done, done);
      chk("state", state_dbg, m_flushing);
      if (flush_done) dut_done++;
   endtask

   task automatic do_ins(input int s, input int t, input logic [DB-1:0] d, input bit dirty);
      set_ins(1'b1, s, t, d, dirty);
      cycle();
      set_ins(1'b0, 0, 0, '0, 1'b0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      set_ins(1'b0, 0, 0, '0, 1'b0);
      set_lk(1'b0, 0, 0);
      flush = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.wb_ready = 1'b0;
      dut_done     = 0;
      apply_reset();
      chk("rst_count", count, 0);
      chk("rst_ent_valid", ent_valid, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_hit_valid", bus.hit_valid, 0);
      chk("rst_miss_valid", bus.miss_valid, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_wb_tag", bus.wb_tag, 0);
      chk("rst_wb_data", bus.wb_data, 0);
      chk("rst_hit_data", bus.hit_data, 0);
      chk("rst_state", state_dbg, 0);

      // Fill plus one: the dirty (15,10) line is pushed out to writeback.
      do_ins(15, 10, 64'd5, 1'b1);
      do_ins(13, 4, 64'd2, 1'b0);
      do_ins(9, 6, 64'd3, 1'b0);
      do_ins(12, 8, 64'd4, 1'b0);
      do_ins(5, 12, 64'd6, 1'b0);
      chk("fill_count", count, 4);
      chk("fill_wb_valid", bus.wb_valid, 1);
      chk("fill_wb_set", bus.wb_set, 15);
      chk("fill_wb_tag", bus.wb_tag, 10);
      chk("fill_wb_data", bus.wb_data, 5);

      // Lookup hit with compaction, then the same key misses.
      set_lk(1'b1, 9, 6);
      cycle();
      chk("lk_hit_valid", bus.hit_valid, 1);
      chk("lk_hit_data", bus.hit_data, 3);
      chk("lk_count", count, 3);
      cycle();
      chk("lk_miss_valid", bus.miss_valid, 1);
      set_lk(1'b0, 0, 0);

      // Retire the pending writeback, refill to 4: order 3,12,8,4 (by tag).
      bus.wb_ready = 1'b1;
      cycle();
      bus.wb_ready = 1'b0;
      do_ins(7, 3, 64'd9, 1'b0);

      // Simultaneous insert and hit at index 2 (12,8).
      set_ins(1'b1, 3, 1, 64'd7, 1'b1);
      set_lk(1'b1, 12, 8);
      cycle();
      set_ins(1'b0, 0, 0, '0, 1'b0);
      set_lk(1'b0, 0, 0);
      chk("sim_count", count, 4);
      chk("sim_wb_valid", bus.wb_valid, 0);
      chk("sim_hit_data", bus.hit_data, 4);

      // Push clean lines out until the dirty (3,1) line lands in writeback.
      do_ins(1, 1, 64'h11, 1'b1);
      do_ins(2, 2, 64'h22, 1'b0);
      do_ins(4, 4, 64'h44, 1'b0);
      do_ins(6, 6, 64'h66, 1'b0);
      chk("bp_wb_set", bus.wb_set, 3);
      chk("bp_wb_tag", bus.wb_tag, 1);
      chk("bp_wb_data", bus.wb_data, 7);

      // Backpressure: oldest (1,1) is dirty and writeback is stalled.
      set_ins(1'b1, 8, 8, 64'h88, 1'b0);
      #1;
      chk("bp_ins_ready_low", bus.ins_ready, 0);
      cycle();
      cycle();
      chk("bp_count_held", count, 4);
      chk("bp_wb_tag_held", bus.wb_tag, 1);
      bus.wb_ready = 1'b1;
      #1;
      chk("bp_ins_ready_high", bus.ins_ready, 1);
      cycle();
      set_ins(1'b0, 0, 0, '0, 1'b0);
      chk("bp_reload_valid", bus.wb_valid, 1);
      chk("bp_reload_set", bus.wb_set, 1);
      chk("bp_reload_data", bus.wb_data, 64'h11);

      // Flush with two dirty entries; writebacks must come oldest first.
      cycle();
      do_ins(10, 10, 64'hA0, 1'b1);
      do_ins(11, 11, 64'hB0, 1'b1);
      hs_tags.delete();
      dut_done = 0;
      flush    = 1'b1;
      cycle();
      flush    = 1'b0;
      repeat (8) cycle();
      chk("fl_hs_count", hs_tags.size(), 2);
      if (hs_tags.size() == 2) begin
         chk("fl_hs_first", hs_tags[0], 10);
         chk("fl_hs_second", hs_tags[1], 11);
      end
      chk("fl_done_pulses", dut_done, 1);
      chk("fl_count", count, 0);

      // Flush of an empty buffer completes one cycle after entering FLUSH.
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      chk("fl_empty_done", flush_done, 1);

      // Random traffic against the model, small key space for hits and duplicates.
      repeat (400) begin
         set_ins($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                 {$urandom, $urandom}, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1 && mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            int idx;
            idx = $urandom_range(0, mq.size() - 1);
            set_lk(1'b1, int'(mq[idx].s), int'(mq[idx].t));
         end else begin
            set_lk($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3));
         end
         bus.wb_ready = $urandom_range(0, 3) != 0;
         flush        = $urandom_range(0, 49) == 0;
         cycle();
      end

      // Reset in the middle of traffic discards everything.
      apply_reset();
      chk("rst2_count", count, 0);
      chk("rst2_wb_valid", bus.wb_valid, 0);
      chk("rst2_state", state_dbg, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
